// File: rtl/vscale_alu_xvec_seq.sv
// Lane-serialised xvec vector ALU: accepts two operand vectors and an op,
// computes LANES_PER_CYCLE lanes per cycle, then holds the result for writeback.
module vscale_alu_xvec_seq #(
  parameter int N_LANES         = 32,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            alu_op,
  input  logic [N_LANES*32-1:0] alu_src_a,
  input  logic [N_LANES*32-1:0] alu_src_b,
  input  logic                  flush,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [N_LANES*32-1:0] alu_out,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int XPR_LEN  = 32;
  localparam int VEC_W    = N_LANES * XPR_LEN;
  localparam int IDX_W    = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int LAST_IDX = N_LANES - LANES_PER_CYCLE;

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both high; valid never depends on ready, and ready is a pure state decode.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   lane_idx_q, lane_idx_d;
  logic [3:0]         op_q, op_d;
  logic [VEC_W-1:0]   a_q, a_d;
  logic [VEC_W-1:0]   b_q, b_d;
  logic [VEC_W-1:0]   out_q, out_d;

  function automatic logic [XPR_LEN-1:0] alu_lane(input logic [3:0] op,
                                                  input logic [XPR_LEN-1:0] a,
                                                  input logic [XPR_LEN-1:0] b);
    logic [4:0] shamt;
    shamt = b[4:0];
    case (op)
      4'd0:    alu_lane = a + b;
      4'd1:    alu_lane = a << shamt;
      4'd4:    alu_lane = a ^ b;
      4'd5:    alu_lane = a >> shamt;
      4'd6:    alu_lane = a | b;
      4'd7:    alu_lane = a & b;
      4'd8:    alu_lane = {31'b0, a == b};
      4'd9:    alu_lane = {31'b0, a != b};
      4'd10:   alu_lane = a - b;
      4'd11:   alu_lane = $unsigned($signed(a) >>> shamt);
      4'd12:   alu_lane = {31'b0, $signed(a) < $signed(b)};
      4'd13:   alu_lane = {31'b0, $signed(a) >= $signed(b)};
      4'd14:   alu_lane = {31'b0, a < b};
      4'd15:   alu_lane = {31'b0, a >= b};
      default: alu_lane = '0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    lane_idx_d = lane_idx_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    out_d      = out_q;
    case (state_q)
      S_IDLE: begin
        // flush outranks a request arriving on the same edge
        if (req_valid && !flush) begin
          op_d       = alu_op;
          a_d        = alu_src_a;
          b_d        = alu_src_b;
          lane_idx_d = '0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          lane_idx_d = '0;
          state_d    = S_IDLE;
        end else begin
          for (int j = 0; j < LANES_PER_CYCLE; j++) begin
            out_d[(int'(lane_idx_q) + j)*XPR_LEN +: XPR_LEN] =
              alu_lane(op_q,
                       a_q[(int'(lane_idx_q) + j)*XPR_LEN +: XPR_LEN],
                       b_q[(int'(lane_idx_q) + j)*XPR_LEN +: XPR_LEN]);
          end
          if (lane_idx_q == IDX_W'(LAST_IDX)) begin
            lane_idx_d = '0;
            state_d    = S_DONE;
          end else begin
            lane_idx_d = lane_idx_q + IDX_W'(LANES_PER_CYCLE);
          end
        end
      end
      S_DONE: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      lane_idx_q <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      out_q      <= out_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign alu_out    = out_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vscale_alu_xvec_seq.sv
// Bench for vscale_alu_xvec_seq: vector table, corner-case sequences and
// randomized requests checked against an arithmetic reference model.
module tb_vscale_alu_xvec_seq;

  localparam int NL  = 32;
  localparam int VW  = NL * 32;
  localparam int LAT = 8;

  typedef logic [VW-1:0] vec_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] alu_op;
  vec_t       alu_src_a;
  vec_t       alu_src_b;
  logic       flush;
  logic       resp_valid;
  logic       resp_ready;
  vec_t       alu_out;
  logic       busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  vec_t exp_q[$];
  vec_rec_t tbl[19];

  vscale_alu_xvec_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .alu_out    (alu_out),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // reference model, written from the arithmetic definition of each op
  function automatic logic [31:0] ref_lane(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint ua, ub, sa, sb, p, r, m;
    m  = 64'h1_0000_0000;
    ua = longint'(a);
    ub = longint'(b);
    sa = (a >= 32'h8000_0000) ? ua - m : ua;
    sb = (b >= 32'h8000_0000) ? ub - m : ub;
    p  = longint'(1) << (ub % 32);
    case (op)
      4'd0:  r = (ua + ub) % m;
      4'd1:  r = (ua * p) % m;
      4'd4:  r = longint'(a ^ b);
      4'd5:  r = ua / p;
      4'd6:  r = longint'(a | b);
      4'd7:  r = longint'(a & b);
      4'd8:  r = (ua == ub) ? 1 : 0;
      4'd9:  r = (ua != ub) ? 1 : 0;
      4'd10: r = (ua - ub + m) % m;
      4'd11: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
      4'd12: r = (sa < sb) ? 1 : 0;
      4'd13: r = (sa >= sb) ? 1 : 0;
      4'd14: r = (ua < ub) ? 1 : 0;
      4'd15: r = (ua >= ub) ? 1 : 0;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic vec_t ref_vec(input logic [3:0] op, input vec_t a, input vec_t b);
    vec_t v;
    for (int i = 0; i < NL; i++) v[i*32 +: 32] = ref_lane(op, a[i*32 +: 32], b[i*32 +: 32]);
    return v;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int i = NL - 1; i >= 0; i--) if (act[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
      $display("FAIL %s: lane %0d got %h expected %h", name, bad,
               act[bad*32 +: 32], exp[bad*32 +: 32]);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] op, input vec_t a, input vec_t b, input string name);
    alu_op    = op;
    alu_src_a = a;
    alu_src_b = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    alu_src_a = ~a;
    alu_src_b = {NL{$urandom}};
    alu_op    = 4'($urandom_range(0, 15));
    check_val({name, " req_ready after accept"}, 32'(req_ready), 32'd0);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [3:0] op, input vec_t a, input vec_t b,
                        input vec_t exp, input string name, input int rr_delay);
    int lat;
    exp_q.push_back(exp);
    accept(op, a, b, name);
    wait_resp(lat);
    check_val({name, " latency"}, 32'(lat), 32'(LAT));
    repeat (rr_delay) tick();
    check_vec({name, " result"}, alu_out, exp_q.pop_front());
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_val({name, " idle after handshake"}, 32'({req_ready, resp_valid, busy}), 32'b100);
  endtask

  initial begin
    vec_t a, b, snap, exp;
    int lat, seen;
    logic [3:0] op;

    tbl[0]  = '{4'd10, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "SUB"};
    tbl[1]  = '{4'd11, 32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF, "SRA31"};
    tbl[2]  = '{4'd12, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "SLT"};
    tbl[3]  = '{4'd14, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "SLTU"};
    tbl[4]  = '{4'd1,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, "SLL"};
    tbl[5]  = '{4'd5,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, "SRL"};
    tbl[6]  = '{4'd11, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, "SRA4"};
    tbl[7]  = '{4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "XOR"};
    tbl[8]  = '{4'd6,  32'h0F0F_0000, 32'h0000_F0F0, 32'h0F0F_F0F0, "OR"};
    tbl[9]  = '{4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "AND"};
    tbl[10] = '{4'd8,  32'h0000_0005, 32'h0000_0005, 32'h0000_0001, "SEQ"};
    tbl[11] = '{4'd9,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, "SNE_eq"};
    tbl[12] = '{4'd9,  32'h0000_0005, 32'h0000_0006, 32'h0000_0001, "SNE_ne"};
    tbl[13] = '{4'd13, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "SGE"};
    tbl[14] = '{4'd15, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "SGEU"};
    tbl[15] = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "ADD_wrap"};
    tbl[16] = '{4'd2,  32'h0000_0007, 32'h0000_0009, 32'h0000_0000, "OP2"};
    tbl[17] = '{4'd3,  32'h0000_0007, 32'h0000_0009, 32'h0000_0000, "OP3"};
    tbl[18] = '{4'd13, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, "SGE_eq"};

    reset = 1'b1; req_valid = 1'b0; alu_op = '0; alu_src_a = '0; alu_src_b = '0;
    flush = 1'b0; resp_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check_val("reset handshake state", 32'({req_ready, resp_valid, busy}), 32'b100);
    check_vec("reset alu_out", alu_out, '0);

    // ADD with lane-index operands
    for (int i = 0; i < NL; i++) begin
      a[i*32 +: 32] = 32'(i);
      b[i*32 +: 32] = 32'h100;
    end
    for (int i = 0; i < NL; i++) exp[i*32 +: 32] = 32'h100 + 32'(i);
    run_op(4'd0, a, b, exp, "ADD_lanes", 0);
    check_val("ADD lane31 constant", exp[31*32 +: 32], 32'h11F);

    // vector table, each op broadcast to all lanes
    for (int t = 0; t < 19; t++)
      run_op(tbl[t].op, {NL{tbl[t].a}}, {NL{tbl[t].b}}, {NL{tbl[t].exp}}, tbl[t].name,
             $urandom_range(0, 2));

    // stall in DONE for 5 cycles while inputs toggle
    for (int i = 0; i < NL; i++) begin
      a[i*32 +: 32] = $urandom;
      b[i*32 +: 32] = $urandom;
    end
    accept(4'd7, a, b, "STALL");
    wait_resp(lat);
    check_val("STALL latency", 32'(lat), 32'(LAT));
    check_vec("STALL result", alu_out, ref_vec(4'd7, a, b));
    snap = alu_out;
    for (int k = 0; k < 5; k++) begin
      alu_src_a = ~alu_src_a;
      req_valid = k[0];
      tick();
      check_vec("STALL alu_out held", alu_out, snap);
      check_val("STALL still pending", 32'({req_ready, resp_valid, busy}), 32'b011);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_val("STALL idle after handshake", 32'({req_ready, resp_valid, busy}), 32'b100);

    // flush on the third RUN cycle
    accept(4'd10, a, b, "FLUSH");
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("FLUSH back to idle", 32'({req_ready, resp_valid, busy}), 32'b100);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (resp_valid) seen = 1;
    end
    check_val("FLUSH no response", 32'(seen), 32'd0);
    for (int i = 0; i < NL; i++) b[i*32 +: 32] = $urandom;
    run_op(4'd4, a, b, ref_vec(4'd4, a, b), "XOR_after_flush", 1);

    // flush beats req_valid in IDLE
    req_valid = 1'b1;
    flush     = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    check_val("FLUSH idle blocks accept", 32'({req_ready, busy}), 32'b10);

    // randomized requests
    for (int n = 0; n < 30; n++) begin
      op = 4'($urandom_range(0, 15));
      for (int i = 0; i < NL; i++) begin
        a[i*32 +: 32] = $urandom;
        b[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? a[i*32 +: 32] : $urandom;
      end
      run_op(op, a, b, ref_vec(op, a, b), "RAND", $urandom_range(0, 3));
    end

    // reset while in DONE
    accept(4'd0, a, b, "RESET_DONE");
    wait_resp(lat);
    check_val("RESET_DONE latency", 32'(lat), 32'(LAT));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("RESET_DONE state", 32'({req_ready, resp_valid, busy}), 32'b100);
    check_vec("RESET_DONE alu_out cleared", alu_out, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
